mpu6050_filter: RTL and testbench

//  Downstream of the MPU6050 I2C reader. Snapshots the six raw 16-bit axis words (ACC_X/Y/Z, GYRO_X/Y/Z) on a fixed

---
 rtl/mpu6050_filter.sv | 136 +++++++++++++
 tb/tb_mpu6050_filter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mpu6050_filter.sv
// Per-axis first-order IIR low-pass (alpha = 2^-K_SHIFT) over six MPU6050 raw words, one channel per cycle.
// Optional MPU_FILT_PRIME_EN: the first pass after reset/init loads the raw sample instead of ramping from zero.
module mpu6050_filter #(
  parameter int SAMPLE_DIV = 500000,
  parameter int K_SHIFT    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init_done,
  input  logic signed [15:0] ACC_X,
  input  logic signed [15:0] ACC_Y,
  input  logic signed [15:0] ACC_Z,
  input  logic signed [15:0] GYRO_X,
  input  logic signed [15:0] GYRO_Y,
  input  logic signed [15:0] GYRO_Z,
  output logic signed [15:0] ACC_X_F,
  output logic signed [15:0] ACC_Y_F,
  output logic signed [15:0] ACC_Z_F,
  output logic signed [15:0] GYRO_X_F,
  output logic signed [15:0] GYRO_Y_F,
  output logic signed [15:0] GYRO_Z_F,
  output logic               filt_valid
);

  localparam int AW = 16 + K_SHIFT;
  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, FILT, PUBLISH} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt;
  logic                  tick;
  logic [2:0]            ch;
  logic signed [15:0]    x_hold [6];
  logic signed [AW-1:0]  acc [6];
  logic signed [15:0]    f_q [6];
  logic signed [AW-1:0]  acc_new;
`ifdef MPU_FILT_PRIME_EN
  logic                  primed;
`endif

  // acc + x - acc/2^K evaluated one bit wider; the true result always fits AW bits
  function automatic logic signed [AW-1:0] iir_step(input logic signed [AW-1:0] a,
                                                    input logic signed [15:0]   x);
    logic signed [AW:0] sum;
    sum = $signed({a[AW-1], a})
        + $signed({{(K_SHIFT+1){x[15]}}, x})
        - $signed({{(K_SHIFT+1){a[AW-1]}}, a[AW-1:K_SHIFT]});
    return sum[AW-1:0];
  endfunction

  function automatic logic signed [AW-1:0] prime_load(input logic signed [15:0] x);
    return {x, {K_SHIFT{1'b0}}};
  endfunction

  function automatic logic signed [15:0] out_word(input logic signed [AW-1:0] a);
    return a[AW-1:K_SHIFT];
  endfunction

  assign tick = (cnt == CNT_LAST);

  always_comb begin
    acc_new = iir_step(acc[ch], x_hold[ch]);
`ifdef MPU_FILT_PRIME_EN
    if (!primed) acc_new = prime_load(x_hold[ch]);
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tick) state_nxt = CAPTURE;
      CAPTURE: state_nxt = FILT;
      FILT:    if (ch == 3'd5) state_nxt = PUBLISH;
      PUBLISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ch    <= '0;
      for (int i = 0; i < 6; i++) begin
        acc[i] <= '0;
        f_q[i] <= '0;
      end
    end else if (!init_done) begin
      // published outputs hold; the filter restarts from zero on the next rise
      state <= IDLE;
      cnt   <= '0;
      ch    <= '0;
      for (int i = 0; i < 6; i++) acc[i] <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= tick ? '0 : cnt + CW'(1);
      if (state == FILT) begin
        acc[ch] <= acc_new;
        ch      <= (ch == 3'd5) ? 3'd0 : ch + 3'd1;
        if (ch == 3'd5) begin
          for (int i = 0; i < 5; i++) f_q[i] <= out_word(acc[i]);
          f_q[5] <= out_word(acc_new);
        end
      end
    end
  end

`ifdef MPU_FILT_PRIME_EN
  always_ff @(posedge clk) begin
    if (rst || !init_done) primed <= 1'b0;
    else if (state == FILT && ch == 3'd5) primed <= 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (state == CAPTURE) begin
      x_hold[0] <= ACC_X;
      x_hold[1] <= ACC_Y;
      x_hold[2] <= ACC_Z;
      x_hold[3] <= GYRO_X;
      x_hold[4] <= GYRO_Y;
      x_hold[5] <= GYRO_Z;
    end
  end

  assign ACC_X_F    = f_q[0];
  assign ACC_Y_F    = f_q[1];
  assign ACC_Z_F    = f_q[2];
  assign GYRO_X_F   = f_q[3];
  assign GYRO_Y_F   = f_q[4];
  assign GYRO_Z_F   = f_q[5];
  assign filt_valid = (state == PUBLISH);

endmodule

// File: tb/tb_mpu6050_filter.sv
// Scoreboard bench for mpu6050_filter (SAMPLE_DIV=16, K_SHIFT=3); honours MPU_FILT_PRIME_EN like the RTL.
module tb_mpu6050_filter;

  localparam int SD = 16;
  localparam int K  = 3;
  // first cycle with init_done high counts as 0, tick lands at count SD-1, outputs 8 cycles later
  localparam int FIRST_LAT = SD - 1 + 8;

  typedef logic [5:0][15:0] vec_t;

  logic clk = 1'b0;
  logic rst, init_done;
  logic [15:0] ax, ay, az, gx, gy, gz;
  logic [15:0] ax_f, ay_f, az_f, gx_f, gy_f, gz_f;
  logic filt_valid;
  vec_t fout;

  mpu6050_filter #(.SAMPLE_DIV(SD), .K_SHIFT(K)) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .ACC_X(ax), .ACC_Y(ay), .ACC_Z(az), .GYRO_X(gx), .GYRO_Y(gy), .GYRO_Z(gz),
    .ACC_X_F(ax_f), .ACC_Y_F(ay_f), .ACC_Z_F(az_f),
    .GYRO_X_F(gx_f), .GYRO_Y_F(gy_f), .GYRO_Z_F(gz_f),
    .filt_valid(filt_valid)
  );

  always #5 clk = ~clk;

  assign fout = {gz_f, gy_f, gx_f, az_f, ay_f, ax_f};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  vec_t exp_q[$];
  int t_start = 0;
  int last_pulse = 0;
  bit first_pending = 1'b0;
  int macc [6];
  bit primed_m;
  string nm [6] = '{"ACC_X_F", "ACC_Y_F", "ACC_Z_F", "GYRO_X_F", "GYRO_Y_F", "GYRO_Z_F"};

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int fdiv(input int a);
    int d;
    d = 1 << K;
    if (a < 0 && (a % d) != 0) return a / d - 1;
    return a / d;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 6; c++) macc[c] = 0;
    primed_m = 1'b0;
  endtask

  task automatic model_step(input vec_t x, output vec_t e);
    int xi;
    for (int c = 0; c < 6; c++) begin
      xi = int'($signed(x[c]));
`ifdef MPU_FILT_PRIME_EN
      if (!primed_m) macc[c] = xi * (1 << K);
      else macc[c] = macc[c] + xi - fdiv(macc[c]);
`else
      macc[c] = macc[c] + xi - fdiv(macc[c]);
`endif
      e[c] = 16'(fdiv(macc[c]));
    end
    primed_m = 1'b1;
  endtask

  task automatic drive(input vec_t x);
    ax = x[0]; ay = x[1]; az = x[2]; gx = x[3]; gy = x[4]; gz = x[5];
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic begin_phase();
    model_reset();
    t_start = cyc;
    first_pending = 1'b1;
  endtask

  // monitor: every pulse must match the head of the queue and arrive on schedule
  always @(negedge clk) begin
    if (filt_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse actual=1 required=0 at cycle %0d", cyc);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        for (int c = 0; c < 6; c++) chk(nm[c], 96'(fout[c]), 96'(e[c]));
        if (first_pending) chk("first_latency", 96'(cyc - t_start), 96'(FIRST_LAT));
        else chk("pulse_period", 96'(cyc - last_pulse), 96'(SD));
      end
      first_pending = 1'b0;
      last_pulse = cyc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t x, e, snap;
    vec_t hand2 [3];
    rst = 1'b1;
    init_done = 1'b1;
    x = '0;
    drive(x);

    // reset held three cycles, then one cycle after release
    repeat (3) begin
      @(negedge clk);
      chk("reset_valid", 96'(filt_valid), 96'(0));
      chk("reset_outputs", fout, 96'(0));
    end
    x = '0;
    x[0] = 16'h0100;
    x[5] = 16'hFFF8;
    drive(x);
    rst = 1'b0;
    begin_phase();
    @(negedge clk);
    chk("post_reset_valid", 96'(filt_valid), 96'(0));
    chk("post_reset_outputs", fout, 96'(0));

    // step response: ACC_X = 256, GYRO_Z = -8
    hand2[0] = '0; hand2[0][0] = 16'd32; hand2[0][5] = 16'hFFFF;
    hand2[1] = '0; hand2[1][0] = 16'd60; hand2[1][5] = 16'hFFFE;
    hand2[2] = '0; hand2[2][0] = 16'd84; hand2[2][5] = 16'hFFFD;
    for (int i = 0; i < 60; i++) begin
      model_step(x, e);
`ifndef MPU_FILT_PRIME_EN
      if (i < 3) e = hand2[i];
`endif
      exp_q.push_back(e);
    end
    wait_to(t_start + FIRST_LAT + SD * 59 + 2);
    chk("step_queue_drained", 96'(exp_q.size()), 96'(0));
    chk("converged_acc_x", 96'(ax_f), 96'(16'd256));
    chk("converged_gyro_z", 96'(gz_f), 96'(16'hFFF8));

    // init_done low with toggling inputs: nothing moves
    snap = fout;
    init_done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      x = {$urandom(), $urandom(), $urandom()};
      drive(x);
      @(negedge clk);
    end
    chk("idle_outputs_hold", fout, snap);

    // abort during FILT channel 1
    x = {16'h0AAA, 16'h0BBB, 16'h0CCC, 16'h0DDD, 16'h0EEE, 16'h0FFF};
    drive(x);
    init_done = 1'b1;
    t_start = cyc;
    wait_to(t_start + 18);
    init_done = 1'b0;
    wait_to(t_start + 40);
    chk("abort_outputs_hold", fout, snap);

    // full-scale words; restart from zero (or primed load)
    x = '0;
    x[0] = 16'h1234; x[1] = 16'h8000; x[2] = 16'hFF00;
    x[3] = 16'h7FFF; x[4] = 16'h0000; x[5] = 16'h0010;
    drive(x);
    init_done = 1'b1;
    begin_phase();
    for (int i = 0; i < 3; i++) begin
      model_step(x, e);
`ifdef MPU_FILT_PRIME_EN
      if (i == 0) e = x;
`endif
      exp_q.push_back(e);
    end
    wait_to(t_start + FIRST_LAT + SD * 2 + 2);
    chk("fullscale_queue_drained", 96'(exp_q.size()), 96'(0));

    // one-cycle reset during FILT channel 3 of the fourth pass
    wait_to(t_start + SD * 3 + 20);
    rst = 1'b1;
    @(negedge clk);
    chk("midfilt_reset_valid", 96'(filt_valid), 96'(0));
    chk("midfilt_reset_outputs", fout, 96'(0));
    rst = 1'b0;
    begin_phase();
    for (int i = 0; i < 2; i++) begin
      model_step(x, e);
`ifdef MPU_FILT_PRIME_EN
      if (i == 0) e = x;
`endif
      exp_q.push_back(e);
    end
    wait_to(t_start + FIRST_LAT + SD + 2);
    chk("after_reset_queue_drained", 96'(exp_q.size()), 96'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
